fp_add_sub: RTL and testbench

FP_ADD_SUB -- requirements
Module: fp_add_sub

---
 rtl/fp_pkg.sv | 33 +++
 rtl/fp_add_sub_if.sv | 23 ++
 rtl/fp_lzc.sv | 20 ++
 rtl/fp_add_sub.sv | 201 ++++++++++++++++++++
 tb/tb_fp_add_sub.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared definitions for the fp_add_sub datapath.
// Holds the sequencing FSM state type, the extra-bit width carried below the
// fraction (guard, round, sticky) and constructors for the special encodings.
// Constructors return a 64-bit word; callers size-cast to their own width.
package fp_pkg;

  localparam int GRS_W = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_DONE
  } state_t;

  // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set.
  function automatic logic [63:0] qnan_word(input int exp_w, input int man_w);
    logic [63:0] w;
    w = ((64'd1 << exp_w) - 64'd1) << man_w;
    w = w | (64'd1 << (man_w - 1));
    return w;
  endfunction

  // Signed infinity: exponent all ones, fraction zero.
  function automatic logic [63:0] inf_word(input logic sign, input int exp_w, input int man_w);
    logic [63:0] w;
    w = ((64'd1 << exp_w) - 64'd1) << man_w;
    w[exp_w + man_w] = sign;
    return w;
  endfunction

endpackage

// File: rtl/fp_add_sub_if.sv
// fp_add_sub_if: request/result bundle of the floating-point adder.
//   start, sub, a, b           : request (driven by master)
//   result, n, v, z, ready, busy : response (driven by slave)
interface fp_add_sub_if #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] result;
  logic         n;
  logic         v;
  logic         z;
  logic         ready;
  logic         busy;

  modport master (output start, sub, a, b, input result, n, v, z, ready, busy);
  modport slave  (input start, sub, a, b, output result, n, v, z, ready, busy);
endinterface

// File: rtl/fp_lzc.sv
// fp_lzc: leading-zero counter.
//   data  : input vector, MSB first
//   count : number of zeros above the highest set bit (WIDTH when data is 0)
module fp_lzc #(
  parameter  int WIDTH = 14,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] count
);

  // Higher indices overwrite lower ones, so the highest set bit wins.
  always_comb begin
    count = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (data[i]) count = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fp_add_sub.sv
// fp_add_sub: multi-cycle IEEE754-style adder/subtractor.
// Sequence IDLE -> ALIGN -> ADD -> NORM -> DONE; a new request may be taken in
// DONE, giving one operation every 4 cycles.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : fp_add_sub_if.slave (start/sub/a/b in; result/n/v/z/ready/busy out)
// Build option FP_ADD_SUB_RNE_EN: round to nearest even and overflow to
// infinity. Without it the result is truncated and overflow saturates to the
// largest finite value (v still set).
module fp_add_sub
  import fp_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input logic         clk,
  input logic         rst_n,
  fp_add_sub_if.slave bus
);

  localparam int W         = 1 + EXP_W + MAN_W;
  localparam int D         = MAN_W + 1 + GRS_W;
  localparam int LZ_W      = $clog2(D + 1);
  localparam int SHIFT_MAX = MAN_W + 3;
  localparam logic [W-1:0]   QNAN     = W'(qnan_word(EXP_W, MAN_W));
  localparam logic [EXP_W:0] EXP_ONES = {1'b0, {EXP_W{1'b1}}};

  state_t state, state_nxt;
  logic accept, ready, busy;

  logic [W-1:0] a_q, b_q;
  logic a_big, nan_any, inf_l, inf_opp, spec;
  logic [W-1:0] big, sml, spec_word;
  logic [EXP_W-1:0] exp_l, exp_s, exp_l_eff, diff;
  logic [D-1:0] sig_l, sig_s_ext, sig_s_al, shift_mask;

  logic sign_r, esub_r, spec_r;
  logic [W-1:0] spec_word_r;
  logic [EXP_W-1:0] exp_r;
  logic [D-1:0] sig_l_r, sig_s_r;
  logic [D:0] sum_r;

  logic [LZ_W-1:0] lz;
  int sh;
  logic [D-1:0] m;
  logic [EXP_W:0] e, e_fin;
  logic inc, res_v;
  logic [MAN_W+1:0] mant;
  logic [MAN_W:0] mant_fin;
  logic [W-1:0] ovf_word, res_word;

  logic [W-1:0] result_r;
  logic n_r, v_r, z_r;

  assign accept = bus.start && (state == S_IDLE || state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE:  begin busy = 1'b0; if (accept) state_nxt = S_ALIGN; end
      S_ALIGN: state_nxt = S_ADD;
      S_ADD:   state_nxt = S_NORM;
      S_NORM:  state_nxt = S_DONE;
      S_DONE:  begin
        busy      = 1'b0;
        ready     = 1'b1;
        state_nxt = accept ? S_ALIGN : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ALIGN: order by magnitude, then shift the smaller significand right,
  // folding everything shifted past the sticky position into sticky.
  always_comb begin
    a_big     = a_q[W-2:0] >= b_q[W-2:0];
    big       = a_big ? a_q : b_q;
    sml       = a_big ? b_q : a_q;
    exp_l     = big[W-2:MAN_W];
    exp_s     = sml[W-2:MAN_W];
    exp_l_eff = (exp_l == '0) ? EXP_W'(1) : exp_l;
    diff      = exp_l_eff - ((exp_s == '0) ? EXP_W'(1) : exp_s);
    sig_l     = {(exp_l != '0), big[MAN_W-1:0], {GRS_W{1'b0}}};
    sig_s_ext = {(exp_s != '0), sml[MAN_W-1:0], {GRS_W{1'b0}}};
    shift_mask = ~({D{1'b1}} << diff);
    if (int'(diff) >= SHIFT_MAX)
      sig_s_al = {{(D-1){1'b0}}, |sig_s_ext};
    else
      sig_s_al = (sig_s_ext >> diff) | {{(D-1){1'b0}}, |(sig_s_ext & shift_mask)};

    // NaN has the largest magnitude, so an infinity can only be the smaller
    // operand when both are infinite.
    nan_any = (&a_q[W-2:MAN_W] && |a_q[MAN_W-1:0]) || (&b_q[W-2:MAN_W] && |b_q[MAN_W-1:0]);
    inf_l   = &exp_l && !(|big[MAN_W-1:0]);
    inf_opp = inf_l && (&exp_s) && !(|sml[MAN_W-1:0]) && (big[W-1] != sml[W-1]);
    spec    = nan_any || inf_l;
    spec_word = (nan_any || inf_opp) ? QNAN : W'(inf_word(big[W-1], EXP_W, MAN_W));
  end

  fp_lzc #(.WIDTH(D)) u_lzc (.data(sum_r[D-1:0]), .count(lz));

  // NORM, shift part: left shift is clamped so the exponent stays >= 1,
  // leaving a subnormal with a clear hidden bit.
  always_comb begin
    sh = 0;
    if (sum_r[D]) begin
      m = {sum_r[D:2], sum_r[1] | sum_r[0]};
      e = {1'b0, exp_r} + (EXP_W+1)'(1);
    end else begin
      sh = (int'(lz) < int'(exp_r) - 1) ? int'(lz) : int'(exp_r) - 1;
      m  = sum_r[D-1:0] << sh;
      e  = (EXP_W+1)'(int'(exp_r) - sh);
    end
  end

`ifdef FP_ADD_SUB_RNE_EN
  assign inc      = m[GRS_W-1] & (m[GRS_W-2] | m[0] | m[GRS_W]);
  assign ovf_word = W'(inf_word(sign_r, EXP_W, MAN_W));
`else
  logic unused_grs;
  assign inc        = 1'b0;
  assign unused_grs = ^m[GRS_W-1:0];
  assign ovf_word   = {sign_r, EXP_ONES[EXP_W-1:0] - EXP_W'(1), {MAN_W{1'b1}}};
`endif

  // NORM, round part: a carry out of rounding renormalises by one place; a
  // subnormal that rounds up into the hidden bit becomes exponent 1.
  always_comb begin
    mant     = {1'b0, m[D-1:GRS_W]} + (MAN_W+2)'(inc);
    mant_fin = mant[MAN_W+1] ? mant[MAN_W+1:1] : mant[MAN_W:0];
    e_fin    = mant[MAN_W+1] ? e + (EXP_W+1)'(1) : e;
    res_v    = 1'b0;
    res_word = '0;
    if (spec_r)
      res_word = spec_word_r;
    else if (sum_r == '0)
      res_word = {~esub_r & sign_r, {(W-1){1'b0}}};
    else if (e_fin >= EXP_ONES) begin
      res_word = ovf_word;
      res_v    = 1'b1;
    end else
      res_word = {sign_r, mant_fin[MAN_W] ? e_fin[EXP_W-1:0] : {EXP_W{1'b0}},
                  mant_fin[MAN_W-1:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      sign_r      <= 1'b0;
      esub_r      <= 1'b0;
      spec_r      <= 1'b0;
      spec_word_r <= '0;
      exp_r       <= '0;
      sig_l_r     <= '0;
      sig_s_r     <= '0;
      sum_r       <= '0;
      result_r    <= '0;
      n_r         <= 1'b0;
      v_r         <= 1'b0;
      z_r         <= 1'b0;
    end else begin
      if (accept) begin
        a_q <= bus.a;
        b_q <= {bus.b[W-1] ^ bus.sub, bus.b[W-2:0]};
      end
      if (state == S_ALIGN) begin
        sign_r      <= big[W-1];
        esub_r      <= big[W-1] ^ sml[W-1];
        spec_r      <= spec;
        spec_word_r <= spec_word;
        exp_r       <= exp_l_eff;
        sig_l_r     <= sig_l;
        sig_s_r     <= sig_s_al;
      end
      if (state == S_ADD)
        sum_r <= esub_r ? ({1'b0, sig_l_r} - {1'b0, sig_s_r})
                        : ({1'b0, sig_l_r} + {1'b0, sig_s_r});
      if (state == S_NORM) begin
        result_r <= res_word;
        n_r      <= res_word[W-1];
        v_r      <= res_v;
        z_r      <= (res_word[W-2:0] == '0);
      end
    end
  end

  assign bus.result = result_r;
  assign bus.n      = n_r;
  assign bus.v      = v_r;
  assign bus.z      = z_r;
  assign bus.ready  = ready;
  assign bus.busy   = busy;

endmodule

// File: tb/tb_fp_add_sub.sv
module tb_fp_add_sub;
  localparam int EXP_W = 5;
  localparam int MAN_W = 10;

`ifdef FP_ADD_SUB_RNE_EN
  localparam logic [15:0] E_OVF      = 16'h7C00;
  localparam logic [15:0] E_TIE_ODD  = 16'h3C02;
  localparam logic [15:0] E_FAR_SUB  = 16'h3C00;
`else
  localparam logic [15:0] E_OVF      = 16'h7BFF;
  localparam logic [15:0] E_TIE_ODD  = 16'h3C01;
  localparam logic [15:0] E_FAR_SUB  = 16'h3BFF;
`endif

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] res;
    logic        n;
    logic        v;
    logic        z;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_add_sub_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();
  fp_add_sub #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic add(input logic [15:0] a, input logic [15:0] b, input logic sub,
                     input logic [15:0] res, input logic n, input logic v, input logic z,
                     input string name);
    vec_t t;
    t.a = a; t.b = b; t.sub = sub; t.res = res; t.n = n; t.v = v; t.z = z; t.name = name;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Called just after a falling edge; returns the number of falling edges
  // from the accepting edge until ready is seen (-1 if it never arrives).
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                        output int lat);
    bus.a = a; bus.b = b; bus.sub = sub; bus.start = 1'b1;
    lat = -1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.ready) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   lat;
    logic seen;
    bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0;

    add(16'h3C00, 16'h4000, 1'b0, 16'h4200,  1'b0, 1'b0, 1'b0, "add_1_2");
    add(16'h3C00, 16'h3C00, 1'b1, 16'h0000,  1'b0, 1'b0, 1'b1, "cancel");
    add(16'h7BFF, 16'h7BFF, 1'b0, E_OVF,     1'b0, 1'b1, 1'b0, "ovf_max");
    add(16'h3C01, 16'h1000, 1'b0, E_TIE_ODD, 1'b0, 1'b0, 1'b0, "tie_odd");
    add(16'h3C00, 16'h1000, 1'b0, 16'h3C00,  1'b0, 1'b0, 1'b0, "tie_even");
    add(16'h3C00, 16'h4000, 1'b1, 16'hBC00,  1'b1, 1'b0, 1'b0, "sub_neg");
    add(16'hC000, 16'h3C00, 1'b0, 16'hBC00,  1'b1, 1'b0, 1'b0, "mixed_sign");
    add(16'h8000, 16'h8000, 1'b0, 16'h8000,  1'b1, 1'b0, 1'b1, "neg_zeros");
    add(16'h0000, 16'h0000, 1'b1, 16'h0000,  1'b0, 1'b0, 1'b1, "zero_minus_zero");
    add(16'h7C01, 16'h3C00, 1'b0, 16'h7E00,  1'b0, 1'b0, 1'b0, "nan_in");
    add(16'hFC00, 16'h3C00, 1'b0, 16'hFC00,  1'b1, 1'b0, 1'b0, "neg_inf_fin");
    add(16'h3C00, 16'hFC00, 1'b1, 16'h7C00,  1'b0, 1'b0, 1'b0, "fin_minus_neginf");
    add(16'h0001, 16'h0001, 1'b0, 16'h0002,  1'b0, 1'b0, 1'b0, "subn_add");
    add(16'h0400, 16'h03FF, 1'b1, 16'h0001,  1'b0, 1'b0, 1'b0, "to_subnormal");
    add(16'h3C01, 16'h3C00, 1'b1, 16'h1400,  1'b0, 1'b0, 1'b0, "lz_shift");
    add(16'h3C00, 16'h0001, 1'b0, 16'h3C00,  1'b0, 1'b0, 1'b0, "far_sticky");
    add(16'h3C00, 16'h0001, 1'b1, E_FAR_SUB, 1'b0, 1'b0, 1'b0, "far_borrow");
    add(16'h7800, 16'h7800, 1'b0, E_OVF,     1'b0, 1'b1, 1'b0, "ovf_carry");
    add(16'h7C00, 16'h7C00, 1'b1, 16'h7E00,  1'b0, 1'b0, 1'b0, "inf_minus_inf");

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_result", 32'(bus.result), 32'h0);
    check("rst_flags", {28'h0, bus.n, bus.v, bus.z, bus.ready}, 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);

    // Start is already high on the first edge after reset release; each later
    // vector is requested in DONE, so lat==4 also checks back-to-back rate.
    rst_n = 1'b1;
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, lat);
      check({vecs[i].name, " lat"},    32'(lat), 32'd4);
      check({vecs[i].name, " result"}, 32'(bus.result), 32'(vecs[i].res));
      check({vecs[i].name, " nvz"},    {29'h0, bus.n, bus.v, bus.z},
                                       {29'h0, vecs[i].n, vecs[i].v, vecs[i].z});
      check({vecs[i].name, " busy"},   32'(bus.busy), 32'h0);
    end

    @(negedge clk);
    check("ready_pulse", 32'(bus.ready), 32'h0);
    check("result_held", 32'(bus.result), 32'h7E00);

    // Start held high in ALIGN with new operands must not disturb the op.
    bus.a = 16'h7C00; bus.b = 16'h7C00; bus.sub = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    check("busy_align", 32'(bus.busy), 32'h1);
    bus.a = 16'h3C00; bus.b = 16'h4000; bus.sub = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    lat = -1;
    for (int i = 3; i <= 12; i++) begin
      @(negedge clk);
      if (bus.ready) begin
        lat = i;
        break;
      end
    end
    check("ignore lat", 32'(lat), 32'd4);
    check("ignore result", 32'(bus.result), 32'h7E00);
    check("ignore v", 32'(bus.v), 32'h0);
    @(negedge clk);
    check("ignore no_second_ready", 32'(bus.ready), 32'h0);

    // Reset in ADD abandons the op and clears outputs asynchronously.
    run_op(16'hC000, 16'h3C00, 1'b0, lat);
    check("pre_reset result", 32'(bus.result), 32'hBC00);
    @(negedge clk);
    bus.a = 16'h3C00; bus.b = 16'h4000; bus.sub = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("busy_add", 32'(bus.busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("midop_rst result", 32'(bus.result), 32'h0);
    check("midop_rst flags", {28'h0, bus.n, bus.v, bus.z, bus.ready}, 32'h0);
    check("midop_rst busy", 32'(bus.busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.ready || bus.busy) seen = 1'b1;
    end
    check("no_ready_after_rst", 32'(seen), 32'h0);
    check("result_after_rst", 32'(bus.result), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end
endmodule
